// File: rtl/tag_alloc.sv
// Round-robin tag allocator: offers the first free tag at or after a circular
// search pointer, tracks busy tags, their count, and a sticky bad-free error.
module tag_alloc #(
  parameter int W = 32
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       flush_i,
  input  logic                       alloc_i,
  output logic                       alloc_rdy_o,
  output logic [$clog2(W)-1:0]       alloc_tag_o,
  input  logic                       free_i,
  input  logic [$clog2(W)-1:0]       free_tag_i,
  output logic [W-1:0]               busy_o,
  output logic [$clog2(W):0]         busy_cnt_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int TW = $clog2(W);

  logic [W-1:0]  busy_r;
  logic [TW-1:0] ptr_r;
  logic [TW:0]   cnt_r;
  logic          err_r;

  logic          found;
  logic [TW-1:0] offer_tag;
  logic [TW-1:0] idx;
  logic          alloc_fire;
  logic          free_ok;
  logic          free_bad;
  logic [W-1:0]  busy_nxt;
  logic [TW:0]   cnt_nxt;

  // Circular search from ptr_r; TW-bit index addition wraps mod W for free.
  always_comb begin
    found     = 1'b0;
    offer_tag = '0;
    idx       = '0;
    for (int d = 0; d < W; d++) begin
      idx = ptr_r + TW'(d);
      if (!found && !busy_r[idx]) begin
        found     = 1'b1;
        offer_tag = idx;
      end
    end
  end

  assign alloc_rdy_o = found;
  assign alloc_tag_o = offer_tag;

  assign alloc_fire = alloc_i & found;
  // Free checks pre-edge state, so freeing the tag being allocated this cycle is an error.
  assign free_ok    = free_i & busy_r[free_tag_i];
  assign free_bad   = free_i & ~busy_r[free_tag_i];

  always_comb begin
    busy_nxt = busy_r;
    if (alloc_fire) busy_nxt[offer_tag] = 1'b1;
    if (free_ok)    busy_nxt[free_tag_i] = 1'b0;
    cnt_nxt = cnt_r + (TW+1)'(alloc_fire) - (TW+1)'(free_ok);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      busy_r <= '0;
      ptr_r  <= '0;
      cnt_r  <= '0;
      err_r  <= 1'b0;
    end else if (flush_i) begin
      busy_r <= '0;
      ptr_r  <= '0;
      cnt_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt;
      cnt_r  <= cnt_nxt;
      if (alloc_fire) ptr_r <= offer_tag + TW'(1);
      if (free_bad)   err_r <= 1'b1;
    end
  end

  assign busy_o     = busy_r;
  assign busy_cnt_o = cnt_r;
  assign idle_o     = (cnt_r == '0);
  assign err_o      = err_r;

endmodule

// File: doc/tag_alloc.md
Name: tag_alloc

Overview:
- Round-robin tag allocator that shares a pool of W tags (slots) among one allocating client and one releasing client.
- Holds a busy vector and a circular search pointer. Each cycle it offers the first free tag at or after the pointer, searching upward circularly.
- Sits in front of any W-entry tracked resource (outstanding-request table, reorder slots) and replaces ad-hoc free-list FIFOs.

Parameters:
- W, 32, number of tags; power of two, W >= 2.
- TW, $clog2(W), tag width; derived, not overridable.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all allocations; has priority over all other inputs.
- alloc_i  in  1  allocation request; consumed only when alloc_rdy_o=1.
- alloc_rdy_o  out  1  at least one tag is free.
- alloc_tag_o  out  TW  offered tag; valid only when alloc_rdy_o=1.
- free_i  in  1  release request.
- free_tag_i  in  TW  tag being released.
- busy_o  out  W  registered busy vector; bit t set while tag t is allocated.
- busy_cnt_o  out  TW+1  number of allocated tags, 0..W.
- idle_o  out  1  busy_cnt_o == 0.
- err_o  out  1  sticky error: a tag was freed while not allocated.

Behaviour:
- State registers: busy_r[W-1:0], ptr_r[TW-1:0], cnt_r[TW:0], err_r.
- Reset (async assert, sync release): busy_r=0, ptr_r=0, cnt_r=0, err_r=0. Outputs after reset: alloc_rdy_o=1, alloc_tag_o=0, busy_o=0, busy_cnt_o=0, idle_o=1, err_o=0.
- Offer logic is combinational from registered state only; no input-to-output combinational path.
  - alloc_rdy_o = (busy_r != all-ones).
  - alloc_tag_o = smallest circular distance d >= 0 such that busy_r[(ptr_r+d) mod W]==0.
  - When alloc_rdy_o=0, alloc_tag_o=0.
- Allocate (alloc_i & alloc_rdy_o): set busy_r[alloc_tag_o] and set ptr_r = (alloc_tag_o+1) mod W, so tag W-1 wraps the pointer to 0. Allocation latency is 0 cycles (tag is presented in the same cycle it is accepted).
- alloc_i while alloc_rdy_o=0: ignored; no state change and no error.
- Free (free_i) with busy_r[free_tag_i]=1: clear that bit. ptr_r is unchanged. The freed tag becomes offerable in the next cycle, not the same cycle.
- Free with busy_r[free_tag_i]=0: no busy/cnt change; err_r set to 1.
  - err_r stays set until reset or flush_i.
  - This includes freeing the tag currently offered, even if it is allocated in the same cycle: the free sees pre-edge state.
- Simultaneous valid alloc and free (different tags): both apply in the same edge; cnt_r unchanged.
- Full pool (cnt_r==W) with free_i: tag released; alloc_rdy_o=1 next cycle, offering the first free tag from ptr_r.
- Counter: cnt_r += accepted alloc, -= valid free; never exceeds W and never underflows.
- flush_i: busy_r=0, cnt_r=0, ptr_r=0, err_r=0 at the edge. alloc_i and free_i in the same cycle are discarded (no error).
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of outstanding allocations.
- Assertions for the bench:
  - alloc_tag_o is never a busy tag when alloc_rdy_o=1.
  - popcount(busy_r) == cnt_r.
  - idle_o == (cnt_r==0).

Test Plan:
- Reset, W=8, alloc_i held high for 8 cycles -> tags 0,1,...,7 in order; alloc_rdy_o=0 after the 8th; busy_o=8'hFF; busy_cnt_o=8.
- From full, free tag 3, then alloc next cycle -> alloc_rdy_o=1 and alloc_tag_o=3 one cycle after the free; ptr_r becomes 4; busy_o=8'hFF.
- Allocate 0..5, free 1 and 2, then alloc twice -> tags 6, 7 offered first; then wrap gives tag 1. Confirms the round-robin pointer, not lowest-free.
- Same cycle: alloc (offer 4) and free tag 0 -> busy_o loses bit 0 and gains bit 4; busy_cnt_o unchanged; err_o=0.
- Free tag 5 while not allocated -> err_o=1 from the next cycle and held; busy_cnt_o unchanged; flush_i clears err_o, busy_o and ptr so the next offer is 0.
- Assert arst_n_i mid-stream with 5 tags busy -> outputs return to reset values immediately; first offer after release is tag 0.
